// File: rtl/dii_package.sv
// Shared debug-interconnect types.
//   dii_flit          : one ring flit (valid, last, 16-bit data).
//   ring_term_state_t : sink FSM state of debug_ring_terminate.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } ring_term_state_t;

endpackage

// File: rtl/debug_ring_terminate_fifo.sv
// Generic dii_flit FIFO with valid/ready handshake on both sides.
//   clk, rst  : clock, synchronous active-high reset
//   in        : write-side flit, in_ready high while count < DEPTH
//   out       : head flit, out.valid high while FIFO is not empty
//   out_ready : read-side ready
// No empty-FIFO bypass: a written flit is visible one cycle later.
module debug_ring_terminate_fifo
  import dii_package::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in,
  output logic    in_ready,
  output dii_flit out,
  input  logic    out_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  logic [16:0] mem_q [DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic        push, pop;

  // Ready depends on the registered count only, never on out_ready.
  assign in_ready = !rst && (count_q < cnt_t'(DEPTH));
  assign push     = in.valid && in_ready;
  assign pop      = out.valid && out_ready;

  always_comb begin
    out.valid = (count_q != '0);
    out.last  = out.valid & mem_q[rd_ptr_q][16];
    out.data  = out.valid ? mem_q[rd_ptr_q][15:0] : 16'h0000;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + cnt_t'(push) - cnt_t'(pop);
    // Explicit wrap so non-power-of-two depths work.
    if (push) wr_ptr_d = (wr_ptr_q == ptr_t'(DEPTH - 1)) ? '0 : wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == ptr_t'(DEPTH - 1)) ? '0 : rd_ptr_q + ptr_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in.last, in.data};
  end

endmodule

// File: rtl/debug_ring_terminate.sv
// Terminates the open end of a two-channel debug ring.
//   clk, rst        : clock, synchronous active-high reset
//   ring_in0        : channel 0 flits, turned around into channel 1 via a FIFO
//   ring_in0_ready  : turn-around FIFO has space
//   ring_in1        : channel 1 flits, sunk unconditionally
//   ring_in1_ready  : high whenever not in reset
//   ring_out1       : turned-around flits into the start of channel 1
//   ring_out1_ready : downstream ready
//   drop_count      : saturating count of dropped channel 1 packets
//   drop_event      : one-cycle pulse per dropped packet
// Macro DEBUG_RING_TERMINATE_DROP_CNT_EN enables drop_count/drop_event;
// otherwise both are tied to 0.
module debug_ring_terminate
  import dii_package::*;
#(
  parameter int unsigned BUFFER_SIZE    = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  dii_flit                   ring_in0,
  output logic                      ring_in0_ready,
  input  dii_flit                   ring_in1,
  output logic                      ring_in1_ready,
  output dii_flit                   ring_out1,
  input  logic                      ring_out1_ready,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      drop_event
);

  debug_ring_terminate_fifo #(
    .DEPTH(BUFFER_SIZE)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in       (ring_in0),
    .in_ready (ring_in0_ready),
    .out      (ring_out1),
    .out_ready(ring_out1_ready)
  );

  ring_term_state_t state_q, state_d;
  logic             accept1;
  logic             pkt_done;
  logic             unused_in1_data;

  assign ring_in1_ready  = !rst;
  assign accept1         = ring_in1.valid && ring_in1_ready;
  assign unused_in1_data = ^ring_in1.data;

  always_comb begin
    state_d  = state_q;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept1) begin
          pkt_done = ring_in1.last;
          state_d  = ring_in1.last ? IDLE : IN_PKT;
        end
      end
      IN_PKT: begin
        if (accept1 && ring_in1.last) begin
          pkt_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef DEBUG_RING_TERMINATE_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;
  logic                      drop_event_q, drop_event_d;

  always_comb begin
    drop_count_d = drop_count_q;
    drop_event_d = pkt_done;
    // Saturate instead of wrapping.
    if (pkt_done && (drop_count_q != '1)) drop_count_d = drop_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
      drop_event_q <= 1'b0;
    end else begin
      drop_count_q <= drop_count_d;
      drop_event_q <= drop_event_d;
    end
  end

  assign drop_count = drop_count_q;
  assign drop_event = drop_event_q;
`else
  logic unused_pkt_done;

  assign unused_pkt_done = pkt_done;
  assign drop_count      = '0;
  assign drop_event      = 1'b0;
`endif

endmodule
